// File: rtl/vga_cell_scanout.sv
// 640x480@60 VGA scan-out of an 80x60 grid of 8x8 RGB332 colour cells read from VRAM.
// Three-stage pipeline: address + flags, VRAM read, registered pixel/sync outputs.
module vga_cell_scanout #(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter int          COLS      = 80,
  parameter logic [12:0] BASE_ADDR = 13'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  displayRdData,
  output logic [12:0] displayAddr,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Cell address wraps modulo 8192; row*COLS is a constant multiply (shift-add).
  function automatic logic [12:0] cell_addr(input logic [HW-1:0] h, input logic [VW-1:0] v);
    logic [12:0] row;
    logic [12:0] col;
    row = 13'(v >> 3);
    col = 13'(h >> 3);
    return BASE_ADDR + 13'(row * 13'(COLS)) + col;
  endfunction

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          act_p0, hs_p0, vs_p0, fs_p0;
  logic [12:0]   addr_q;
  logic          act_p1_q, hs_p1_q, vs_p1_q, fs_p1_q;
  logic          act_p2_q, hs_p2_q, vs_p2_q, fs_p2_q;
  logic [7:0]    pix_q;
  logic          hsync_q, vsync_q, fs_q;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  assign act_p0 = (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign hs_p0  = (h_q >= HS_START) && (h_q < HS_END);
  assign vs_p0  = (v_q >= VS_START) && (v_q < VS_END);
  assign fs_p0  = (h_q == '0) && (v_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q      <= '0;
      v_q      <= '0;
      addr_q   <= BASE_ADDR;
      act_p1_q <= 1'b0;
      hs_p1_q  <= 1'b0;
      vs_p1_q  <= 1'b0;
      fs_p1_q  <= 1'b0;
      act_p2_q <= 1'b0;
      hs_p2_q  <= 1'b0;
      vs_p2_q  <= 1'b0;
      fs_p2_q  <= 1'b0;
      pix_q    <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      // Stage 1: VRAM address and timing flags for the current (h,v)
      addr_q   <= cell_addr(h_q, v_q);
      act_p1_q <= act_p0;
      hs_p1_q  <= hs_p0;
      vs_p1_q  <= vs_p0;
      fs_p1_q  <= fs_p0;
      // Stage 2: VRAM read in flight
      act_p2_q <= act_p1_q;
      hs_p2_q  <= hs_p1_q;
      vs_p2_q  <= vs_p1_q;
      fs_p2_q  <= fs_p1_q;
      // Stage 3: blanked pixel and active-low syncs
      pix_q    <= act_p2_q ? displayRdData : 8'h00;
      hsync_q  <= ~hs_p2_q;
      vsync_q  <= ~vs_p2_q;
      fs_q     <= fs_p2_q;
    end
  end

  assign displayAddr = addr_q;
  assign red         = pix_q[7:5];
  assign green       = pix_q[4:2];
  assign blue        = pix_q[1:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frameStart  = fs_q;

endmodule

// File: tb/tb_vga_cell_scanout.sv
// Scoreboard bench: a full-timing instance (BASE 0) and a compact-timing instance
// (BASE 8000) share clock and reset; each VRAM model returns byte[a] = a[7:0].
module tb_vga_cell_scanout;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst_n;
  logic [7:0]  m_rd, s_rd;
  logic [12:0] m_addr, s_addr;
  logic        m_hs, m_vs, m_fs, s_hs, s_vs, s_fs;
  logic [2:0]  m_r, m_g, s_r, s_g;
  logic [1:0]  m_b, s_b;

  vga_cell_scanout dut_m (
    .clk(clk), .rst_n(rst_n), .displayRdData(m_rd), .displayAddr(m_addr),
    .hsync(m_hs), .vsync(m_vs), .red(m_r), .green(m_g), .blue(m_b), .frameStart(m_fs)
  );

  vga_cell_scanout #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(200), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .COLS(80), .BASE_ADDR(13'd8000)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .displayRdData(s_rd), .displayAddr(s_addr),
    .hsync(s_hs), .vsync(s_vs), .red(s_r), .green(s_g), .blue(s_b), .frameStart(s_fs)
  );

  always @(posedge clk) begin
    m_rd <= m_addr[7:0];
    s_rd <= s_addr[7:0];
  end

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int nvec, nmis;
  bit armed;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int c; int w; } run_t;
  typedef struct { int c; int v; } probe_t;

  int     q_mfs[$], q_sfs[$];
  run_t   q_mhs[$], q_svs[$];
  probe_t q_mpix[$], q_spix[$], q_madr[$], q_sadr[$];

  int   mhs_start, svs_start;
  logic mhs_prev, svs_prev;

  always @(negedge clk) begin
    if (!rst_n || !armed) begin
      mhs_prev = 1'b1;
      svs_prev = 1'b1;
    end else begin
      run_t   e;
      probe_t p;
      if (m_fs === 1'b1) begin
        if (q_mfs.size() == 0) chk("m_fs_unexpected", cyc, -1);
        else chk("m_fs_cyc", cyc, q_mfs.pop_front());
      end
      if (s_fs === 1'b1) begin
        if (q_sfs.size() == 0) chk("s_fs_unexpected", cyc, -1);
        else chk("s_fs_cyc", cyc, q_sfs.pop_front());
      end
      if (m_hs !== 1'b1 && mhs_prev) mhs_start = cyc;
      if (m_hs === 1'b1 && !mhs_prev) begin
        if (q_mhs.size() == 0) chk("m_hs_unexpected", mhs_start, -1);
        else begin
          e = q_mhs.pop_front();
          chk("m_hs_start", mhs_start, e.c);
          chk("m_hs_width", cyc - mhs_start, e.w);
        end
      end
      mhs_prev = (m_hs === 1'b1);
      if (s_vs !== 1'b1 && svs_prev) svs_start = cyc;
      if (s_vs === 1'b1 && !svs_prev) begin
        if (q_svs.size() == 0) chk("s_vs_unexpected", svs_start, -1);
        else begin
          e = q_svs.pop_front();
          chk("s_vs_start", svs_start, e.c);
          chk("s_vs_width", cyc - svs_start, e.w);
        end
      end
      svs_prev = (s_vs === 1'b1);
      if (q_mpix.size() > 0 && q_mpix[0].c == cyc) begin
        p = q_mpix.pop_front();
        chk("m_pix", {m_r, m_g, m_b}, p.v);
      end
      if (q_spix.size() > 0 && q_spix[0].c == cyc) begin
        p = q_spix.pop_front();
        chk("s_pix", {s_r, s_g, s_b}, p.v);
      end
      if (q_madr.size() > 0 && q_madr[0].c == cyc) begin
        p = q_madr.pop_front();
        chk("m_addr", m_addr, p.v);
      end
      if (q_sadr.size() > 0 && q_sadr[0].c == cyc) begin
        p = q_sadr.pop_front();
        chk("s_addr", s_addr, p.v);
      end
    end
  end

  task automatic check_reset();
    chk("rst_m_hsync", m_hs, 1);
    chk("rst_m_vsync", m_vs, 1);
    chk("rst_m_rgb", {m_r, m_g, m_b}, 0);
    chk("rst_m_fs", m_fs, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_s_hsync", s_hs, 1);
    chk("rst_s_vsync", s_vs, 1);
    chk("rst_s_rgb", {s_r, s_g, s_b}, 0);
    chk("rst_s_fs", s_fs, 0);
    chk("rst_s_addr", s_addr, 8000);
  endtask

  task automatic drain();
    chk("left_m_fs", q_mfs.size(), 0);
    chk("left_s_fs", q_sfs.size(), 0);
    chk("left_m_hs", q_mhs.size(), 0);
    chk("left_s_vs", q_svs.size(), 0);
    chk("left_m_pix", q_mpix.size(), 0);
    chk("left_s_pix", q_spix.size(), 0);
    chk("left_m_addr", q_madr.size(), 0);
    chk("left_s_addr", q_sadr.size(), 0);
    q_mfs.delete(); q_sfs.delete(); q_mhs.delete(); q_svs.delete();
    q_mpix.delete(); q_spix.delete(); q_madr.delete(); q_sadr.delete();
  endtask

  task automatic add(inout probe_t q[$], input int c, input int v);
    q.push_back('{c: c, v: v});
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    armed = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset();
    repeat (5) @(posedge clk);

    // Two small-instance frames; main instance covers lines 0..42.
    q_mfs = '{3};
    q_sfs = '{3, 16643, 33283};
    for (int l = 0; l < 42; l++) q_mhs.push_back('{c: l * 800 + 659, w: 96});
    q_svs.push_back('{c: 16163, w: 160});
    q_svs.push_back('{c: 32803, w: 160});
    add(q_mpix, 3, 8'h00);     add(q_mpix, 11, 8'h01);
    add(q_mpix, 227, 8'h1C);   add(q_mpix, 642, 8'h4F);
    add(q_mpix, 643, 8'h00);   add(q_mpix, 802, 8'h00);
    add(q_mpix, 811, 8'h01);   add(q_mpix, 6403, 8'h50);
    add(q_mpix, 13339, 8'hE3); add(q_mpix, 32667, 8'h00);
    add(q_madr, 1, 0);     add(q_madr, 8, 0);      add(q_madr, 9, 1);
    add(q_madr, 640, 79);  add(q_madr, 6401, 80);  add(q_madr, 32665, 483);
    add(q_spix, 3, 8'h40); add(q_spix, 67, 8'h00);
    add(q_spix, 15363, 8'hC0); add(q_spix, 16003, 8'h00);
    add(q_sadr, 1, 8000);  add(q_sadr, 9, 8001);   add(q_sadr, 15361, 1728);

    #2 rst_n = 1'b1;
    armed = 1'b1;
    repeat (33900) @(posedge clk);

    // Main instance is at v=42, h=300: abort the line mid-flight.
    #2 rst_n = 1'b0;
    armed = 1'b0;
    #1 drain();
    check_reset();
    repeat (3) @(posedge clk);

    q_mfs = '{3};
    q_sfs = '{3};
    q_mhs.push_back('{c: 659, w: 96});
    q_mhs.push_back('{c: 1459, w: 96});
    add(q_mpix, 11, 8'h01);
    add(q_madr, 1, 0);
    add(q_madr, 9, 1);
    add(q_spix, 3, 8'h40);
    add(q_sadr, 1, 8000);

    #2 rst_n = 1'b1;
    armed = 1'b1;
    repeat (1600) @(posedge clk);
    #2 drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
